// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the APB TX-data write path and the UART transmitter.
// Define UART_TX_FIFO_LEVEL_EN to drive the live occupancy count on level.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_n,
    output logic [WIDTH-1:0]      dout,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  rd_ok;
    logic                  wr_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign rd_ok = !rd_n && !fifo_empty;
    assign wr_ok = !wr_n && (!fifo_full || rd_ok);

    always_comb begin
        count_nxt = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout       <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            count      <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == DEPTH_CNT);
            overflow   <= !wr_n && !wr_ok;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    assign level = count;
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a queue-based reference model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_n;
    logic [7:0] din;
    logic       rd_n;
    logic [7:0] dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic [4:0] level;

    int total = 0;
    int passed = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf;

    uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_n(wr_n),
        .din(din),
        .rd_n(rd_n),
        .dout(dout),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_level();
`ifdef UART_TX_FIFO_LEVEL_EN
        return q.size();
`else
        return 0;
`endif
    endfunction

    task automatic compare();
        check("dout", dout, m_dout);
        check("fifo_empty", fifo_empty, q.size() == 0);
        check("fifo_full", fifo_full, q.size() == 16);
        check("overflow", overflow, m_ovf);
        check("level", level, exp_level());
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic pop;
        logic push;
        wr_n = ~w;
        din  = d;
        rd_n = ~r;
        @(posedge clk);
        pop  = r && q.size() > 0;
        push = w && (q.size() < 16 || pop);
        m_ovf = w && !push;
        if (pop)
            m_dout = q.pop_front();
        if (push)
            q.push_back(d);
        #1;
        compare();
        wr_n = 1'b1;
        rd_n = 1'b1;
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_n = 1'b1;
        rd_n = 1'b1;
        din  = 8'h00;
        model_reset();
        #12;
        compare();
        check("reset_empty_lit", fifo_empty, 1);
        reset_n = 1'b1;

        // single byte round trip
        step(1'b1, 8'hA5, 1'b0);
        check("wr_empty_lit", fifo_empty, 0);
        step(1'b0, 8'h00, 1'b1);
        check("pop_a5_lit", dout, 8'hA5);
        check("pop_empty_lit", fifo_empty, 1);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(i), 1'b0);
        check("full_lit", fifo_full, 1);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_lit", overflow, 1);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_pulse_lit", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_lit", dout, i);
        end
        check("drain_empty_lit", fifo_empty, 1);

        // pointer wrap with interleaved pairs
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
            step(1'b0, 8'h00, 1'b1);
            check("wrap_lit", dout, 8'h40 + i);
        end

        // full with simultaneous read and write
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        check("fullrw_full_lit", fifo_full, 1);
        check("fullrw_ovf_lit", overflow, 0);
        check("fullrw_dout_lit", dout, 8'h10);
        for (int i = 0; i < 16; i++)
            step(1'b0, 8'h00, 1'b1);
        check("fullrw_last_lit", dout, 8'h77);

        // empty with simultaneous read and write
        step(1'b1, 8'h3C, 1'b1);
        check("emptyrw_dout_lit", dout, 8'h77);
        check("emptyrw_empty_lit", fifo_empty, 0);
        step(1'b0, 8'h00, 1'b1);
        check("emptyrw_pop_lit", dout, 8'h3C);
        step(1'b0, 8'h00, 1'b1);
        check("empty_pop_lit", dout, 8'h3C);

        // asynchronous reset with entries queued
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'h50 + i), 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare();
        check("rst_dout_lit", dout, 0);
        check("rst_full_lit", fifo_full, 0);
        #3;
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        check("rst_pop_lit", dout, 0);
        check("rst_pop_empty_lit", fifo_empty, 1);
        step(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synchronous byte FIFO on the system clock between the APB transmit-data register write path and the UART transmitter, active in the TX_FIFO=1 build. It buffers bytes written by the host. It presents the oldest byte on a registered output that the transmitter loads at its start-bit state. The transmitter sees `fifo_empty` and `fifo_full` and pops with a one-cycle active-low read strobe.

## Interface
- DEPTH_LOG2, 4: log2 of entry count; depth = 2^DEPTH_LOG2 (16); legal range 2..8
- WIDTH, 8: data width in bits
- clk  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- wr_n  in  1  active-low write strobe; one byte per low cycle
- din  in  WIDTH  write data, sampled when wr_n=0
- rd_n  in  1  active-low read strobe from transmitter (its fifo_read_tx)
- dout  out  WIDTH  registered head byte, to transmitter tx_dout_reg
- fifo_empty  out  1  registered; 1 when occupancy = 0
- fifo_full  out  1  registered; 1 when occupancy = 2^DEPTH_LOG2
- overflow  out  1  one-cycle pulse: write attempted while full
- level  out  DEPTH_LOG2+1  occupancy count (see Configuration)

## Operation
- Storage: 2^DEPTH_LOG2 x WIDTH register array. Write pointer, read pointer, DEPTH_LOG2 bits each, wrap modulo depth. Occupancy counter is DEPTH_LOG2+1 bits.
- Write accepted: wr_n=0 and (fifo_full=0, or a read is accepted the same cycle). Effect: mem[wptr] <= din, wptr increments.
- Write when full with no accepted read: byte dropped, pointers unchanged, overflow=1 for that one cycle.
- Read accepted: rd_n=0 and fifo_empty=0. Effect: dout <= mem[rptr], rptr increments.
- Read when empty: ignored; dout, pointers and count hold; no error flag.
- Occupancy update per cycle: write accepted only -> count+1; read accepted only -> count-1; both or neither -> unchanged.
- Full and simultaneous read+write: both accepted, count stays at depth, fifo_full stays 1.
- Empty and simultaneous read+write: write accepted, read ignored (no fall-through), count becomes 1.
- fifo_empty and fifo_full are registered from the next-state count, never decoded combinationally from pointers.
- dout holds its last popped value until the next accepted read.
- Reset, including mid-transfer: wptr=0, rptr=0, count=0, fifo_empty=1, fifo_full=0, dout=0, overflow=0, level=0. Memory contents are not reset and are don't-care.

## Timing
- Write sampled at edge N: fifo_empty falls and count increments after edge N. The byte is poppable from cycle N+1.
- Read sampled at edge N: dout is valid after edge N, one cycle of latency. The transmitter samples dout at least two cycles later (tx_load, then start_bit on xmit_pulse), so the margin is met.
- Read strobe is level-sampled: each low cycle is one pop. The transmitter drives it low for exactly one cycle per byte.
- Throughput: one write and one read per cycle sustained.
- overflow asserts in the cycle after the offending edge, for one cycle only.

## Configuration
- UART_TX_FIFO_LEVEL_EN defined: level drives the live occupancy count, 0..2^DEPTH_LOG2, updated with the same timing as the flags.
- UART_TX_FIFO_LEVEL_EN undefined: level is tied to 0; the counter is kept internally for flag generation only. Flag behaviour is identical in both builds.

## Test plan
- Reset, then write 0xA5: after the write edge fifo_empty=0, level=1. Pulse rd_n one cycle: next cycle dout=0xA5, fifo_empty=1, level=0.
- Write 16 bytes 0x00..0x0F: fifo_full=1 after the 16th write. A 17th write (0xFF) gives overflow pulse=1 for one cycle; 16 pops then return 0x00..0x0F in order with no 0xFF.
- Pointer wrap: repeat 40 interleaved write/read pairs with incrementing data. Every popped byte equals its write; level never exceeds 1.
- Full plus simultaneous wr_n=0/rd_n=0 with din=0x77: fifo_full stays 1, overflow=0, level=16. After draining, 0x77 is the last byte out.
- Empty plus simultaneous write 0x3C and read: dout unchanged, level=1. The next pop yields 0x3C. A pop while empty leaves dout=0x3C.
- Assert reset_n=0 with 5 entries queued: fifo_empty=1, fifo_full=0, dout=0, level=0 immediately. A subsequent pop has no effect.
